// File: rtl/prism_sp_pkg.sv
// Shared types and AXI constants for the SP memory engines.
package prism_sp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ADDR,
    ST_DATA
  } axi_rd_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         AXI_PAGE_BYTES = 4096;

endpackage

// File: rtl/axi_read_burst_calc.sv
// Sizes the next read burst so it never exceeds the beat budget, the burst limit
// or the 4 KiB page; results are registered when load is high.
module axi_read_burst_calc
  import prism_sp_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 32,
  parameter int OFFSET_WIDTH   = 3,
  parameter int MAX_BURST_LEN  = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,
  input  logic [AXI_ADDR_WIDTH-1:0] cur_addr,
  input  logic [LEN_WIDTH-1:0]      beats_left,
  output logic [7:0]                arlen,
  output logic [8:0]                burst,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr
);

  logic [12:0] to4k;
  logic [12:0] limit;
  logic [8:0]  burst_c;

  // to4k is never zero since cur_addr is always bus-aligned
  always_comb begin
    to4k  = (13'(AXI_PAGE_BYTES) - {1'b0, cur_addr[11:0]}) >> OFFSET_WIDTH;
    limit = (to4k < 13'(MAX_BURST_LEN)) ? to4k : 13'(MAX_BURST_LEN);
    if (beats_left < LEN_WIDTH'(limit))
      burst_c = 9'(beats_left);
    else
      burst_c = 9'(limit);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      arlen     <= '0;
      burst     <= '0;
      next_addr <= '0;
    end else if (load) begin
      arlen     <= 8'(burst_c - 9'd1);
      burst     <= burst_c;
      next_addr <= cur_addr + (AXI_ADDR_WIDTH'(burst_c) << OFFSET_WIDTH);
    end
  end

endmodule

// File: rtl/axi_to_fifo.sv
// AXI4 read DMA: fetches len bytes from an aligned address in INCR bursts (one
// outstanding) and pushes every returned beat into a downstream FIFO.
module axi_to_fifo
  import prism_sp_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int MAX_BURST_LEN  = 16,
  parameter int LEN_WIDTH      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mem_r_start,
  input  logic [AXI_ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [LEN_WIDTH-1:0]      mem_r_len,
  output logic                      mem_r_busy,
  output logic                      mem_r_done,
  output logic                      mem_r_error,
  output logic                      fifo_w_wr_en,
  output logic [AXI_DATA_WIDTH-1:0] fifo_w_wr_data,
  input  logic                      fifo_w_full,
  input  logic [3:0]                axi_arcache,
  output logic                      axi_ar_arvalid,
  input  logic                      axi_ar_arready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_araddr,
  output logic [7:0]                axi_ar_arlen,
  output logic [2:0]                axi_ar_arsize,
  output logic [1:0]                axi_ar_arburst,
  output logic [3:0]                axi_ar_arid,
  output logic                      axi_ar_arlock,
  output logic [2:0]                axi_ar_arprot,
  output logic [3:0]                axi_ar_arqos,
  output logic [3:0]                axi_ar_arcache,
  output logic                      axi_r_rready,
  input  logic                      axi_r_rvalid,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_rdata,
  input  logic [1:0]                axi_r_rresp,
  input  logic                      axi_r_rlast
);

  localparam int BYTES        = AXI_DATA_WIDTH / 8;
  localparam int OFFSET_WIDTH = $clog2(BYTES);

  axi_rd_state_t             state, state_next;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic [LEN_WIDTH-1:0]      beats_left;
  logic [8:0]                beat_cnt;
  logic [8:0]                burst;
  logic                      err;
  logic                      start_bad;
  logic                      r_hs;
  logic                      last_beat;
  logic                      beat_err;

  axi_read_burst_calc #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .OFFSET_WIDTH  (OFFSET_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_calc (
    .clock     (clock),
    .reset     (reset),
    .load      (state == ST_CALC),
    .cur_addr  (cur_addr),
    .beats_left(beats_left),
    .arlen     (axi_ar_arlen),
    .burst     (burst),
    .next_addr (next_addr)
  );

  assign axi_ar_arsize  = 3'(OFFSET_WIDTH);
  assign axi_ar_arburst = AXI_BURST_INCR;
  assign axi_ar_arid    = '0;
  assign axi_ar_arlock  = 1'b0;
  assign axi_ar_arprot  = '0;
  assign axi_ar_arqos   = '0;
  assign axi_ar_arcache = axi_arcache;

  assign start_bad      = (mem_r_len == '0) || (mem_r_addr[OFFSET_WIDTH-1:0] != '0);
  assign axi_r_rready   = (state == ST_DATA) && !fifo_w_full;
  assign r_hs           = axi_r_rvalid && axi_r_rready;
  assign fifo_w_wr_en   = r_hs;
  assign fifo_w_wr_data = axi_r_rdata;
  assign last_beat      = (beat_cnt == 9'd1);
  // The local beat count is authoritative; a misplaced rlast only flags an error
  assign beat_err       = (axi_r_rresp != AXI_RESP_OKAY) || (axi_r_rlast != last_beat);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (mem_r_start && !start_bad) state_next = ST_CALC;
      ST_CALC: state_next = ST_ADDR;
      ST_ADDR: if (axi_ar_arready) state_next = ST_DATA;
      ST_DATA:
        if (r_hs && last_beat)
          state_next = (beats_left == LEN_WIDTH'(1)) ? ST_IDLE : ST_CALC;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_addr       <= '0;
      beats_left     <= '0;
      beat_cnt       <= '0;
      err            <= 1'b0;
      mem_r_busy     <= 1'b0;
      mem_r_done     <= 1'b0;
      mem_r_error    <= 1'b0;
      axi_ar_arvalid <= 1'b0;
      axi_ar_araddr  <= '0;
    end else begin
      mem_r_done <= 1'b0;
      case (state)
        ST_IDLE:
          if (mem_r_start) begin
            if (start_bad) begin
              mem_r_done  <= 1'b1;
              mem_r_error <= 1'b1;
            end else begin
              cur_addr   <= mem_r_addr;
              beats_left <= LEN_WIDTH'(mem_r_len >> OFFSET_WIDTH)
                          + LEN_WIDTH'(|mem_r_len[OFFSET_WIDTH-1:0]);
              err        <= 1'b0;
              mem_r_busy <= 1'b1;
            end
          end
        ST_CALC: begin
          axi_ar_araddr  <= cur_addr;
          axi_ar_arvalid <= 1'b1;
        end
        ST_ADDR:
          if (axi_ar_arready) begin
            axi_ar_arvalid <= 1'b0;
            beat_cnt       <= burst;
          end
        ST_DATA:
          if (r_hs) begin
            beat_cnt   <= beat_cnt - 9'd1;
            beats_left <= beats_left - LEN_WIDTH'(1);
            if (beat_err) err <= 1'b1;
            if (last_beat) begin
              if (beats_left == LEN_WIDTH'(1)) begin
                mem_r_done  <= 1'b1;
                mem_r_error <= err || beat_err;
                mem_r_busy  <= 1'b0;
              end else begin
                cur_addr <= next_addr;
              end
            end
          end
        default: ;
      endcase
    end
  end

endmodule
